// File: rtl/eth_speed_mgr_if.sv
// -----------------------------------------------------------------------------
// eth_speed_mgr_if
// Groups the per-port MAC status inputs and the PHY / TX-clock control outputs
// of the Ethernet speed manager.
//
//   eth_mode     [NUM_PORTS]    MAC status, 1 = GbE (asynchronous to clk)
//   ena_10       [NUM_PORTS]    MAC status, 1 = 10 Mb (asynchronous to clk)
//   phy_rst_req  [NUM_PORTS]    synchronous, level-sensitive PHY reset request
//   phy_reset_n  [NUM_PORTS]    active-low PHY reset
//   tx_clk_sel   [2*NUM_PORTS]  bits [2i+1:2i]: 00 = 25 MHz, 01 = 2.5 MHz, 10 = 125 MHz
//   tx_clk_en    [NUM_PORTS]    TX clock / gate enable
//   speed_change [NUM_PORTS]    one-cycle pulse when tx_clk_sel updates
//   busy         [NUM_PORTS]    high whenever the port is not in RUN
//
// master: the speed manager itself.  slave: the MAC/PHY side.
// -----------------------------------------------------------------------------
interface eth_speed_mgr_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]   eth_mode;
    logic [NUM_PORTS-1:0]   ena_10;
    logic [NUM_PORTS-1:0]   phy_rst_req;
    logic [NUM_PORTS-1:0]   phy_reset_n;
    logic [2*NUM_PORTS-1:0] tx_clk_sel;
    logic [NUM_PORTS-1:0]   tx_clk_en;
    logic [NUM_PORTS-1:0]   speed_change;
    logic [NUM_PORTS-1:0]   busy;

    modport master (
        input  eth_mode, ena_10, phy_rst_req,
        output phy_reset_n, tx_clk_sel, tx_clk_en, speed_change, busy
    );

    modport slave (
        output eth_mode, ena_10, phy_rst_req,
        input  phy_reset_n, tx_clk_sel, tx_clk_en, speed_change, busy
    );
endinterface

// File: rtl/eth_speed_mgr.sv
// -----------------------------------------------------------------------------
// eth_speed_mgr
// Per-port Ethernet speed manager.  Each port synchronises the MAC speed status,
// waits until a new speed has been seen for STABLE_CYCLES consecutive samples,
// then gates the TX clock off, waits GAP_CYCLES, switches tx_clk_sel, waits
// GAP_CYCLES again and re-enables the clock.  A PHY reset sequence of
// PHY_RST_CYCLES runs after reset and whenever phy_rst_req is asserted.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  asynchronous, active-high reset
//   bus    eth_speed_mgr_if.master (status inputs, PHY/clock control outputs)
//
// Ports are fully independent: each has its own FSM, stability counter and
// gap/reset timer.
// -----------------------------------------------------------------------------
module eth_speed_mgr #(
    parameter int NUM_PORTS      = 2,      // 1..8
    parameter int STABLE_CYCLES  = 1024,   // >= 2
    parameter int GAP_CYCLES     = 64,     // >= 1
    parameter int PHY_RST_CYCLES = 50000   // >= 1
) (
    input  logic            clk,
    input  logic            reset,
    eth_speed_mgr_if.master bus
);

    typedef enum logic [1:0] {
        PHY_RST  = 2'd0,
        RUN      = 2'd1,
        PRE_GAP  = 2'd2,
        POST_GAP = 2'd3
    } state_t;

    localparam logic [1:0] SPD_100M = 2'b00;
    localparam logic [1:0] SPD_10M  = 2'b01;
    localparam logic [1:0] SPD_1G   = 2'b10;

    // One timer per port serves both the PHY reset hold and the clock gaps.
    localparam int TMR_MAX = (GAP_CYCLES > PHY_RST_CYCLES) ? GAP_CYCLES : PHY_RST_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int SW      = $clog2(STABLE_CYCLES + 1);

    localparam logic [TW-1:0] RST_LAST  = TW'(PHY_RST_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_SAT  = SW'(STABLE_CYCLES);

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous MAC status bits
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] mode_meta, mode_sync;
    logic [NUM_PORTS-1:0] ena10_meta, ena10_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_meta  <= '0;
            mode_sync  <= '0;
            ena10_meta <= '0;
            ena10_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the two stages really form a 2-cycle chain.
            mode_meta  <= bus.eth_mode;
            mode_sync  <= mode_meta;
            ena10_meta <= bus.ena_10;
            ena10_sync <= ena10_meta;
        end
    end

    wire [NUM_PORTS-1:0]   phy_reset_n_w;
    wire [NUM_PORTS-1:0]   tx_clk_en_w;
    wire [NUM_PORTS-1:0]   speed_change_w;
    wire [NUM_PORTS-1:0]   busy_w;
    wire [2*NUM_PORTS-1:0] tx_clk_sel_w;

    // ------------------------------------------------------------------
    // Per-port FSM, stability counter and gap/reset timer
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        state_t        state_q, state_d;
        logic [1:0]    code;
        logic [1:0]    sel_q, sel_d;
        logic [1:0]    cand_q, cand_d;
        logic [SW-1:0] stab_q, stab_d, stab_inc;
        logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
        logic          chg_q, chg_d;

        // GbE wins over the 10 Mb flag; code 11 is unreachable.
        assign code = mode_sync[i] ? SPD_1G : (ena10_sync[i] ? SPD_10M : SPD_100M);

        // Saturating increments: the counters stick at their ceiling.
        assign tmr_inc  = (tmr_q == '1)        ? tmr_q  : tmr_q  + TW'(1);
        assign stab_inc = (stab_q == STAB_SAT) ? stab_q : stab_q + SW'(1);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= PHY_RST;
                sel_q   <= SPD_100M;
                cand_q  <= SPD_100M;
                stab_q  <= '0;
                tmr_q   <= '0;
                chg_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                sel_q   <= sel_d;
                cand_q  <= cand_d;
                stab_q  <= stab_d;
                tmr_q   <= tmr_d;
                chg_q   <= chg_d;
            end
        end

        always_comb begin
            // NOTE: every output of this block is given a value before the
            // case statement, so no path leaves one unassigned (no latch).
            state_d = state_q;
            sel_d   = sel_q;
            cand_d  = cand_q;
            stab_d  = stab_q;
            tmr_d   = tmr_q;
            chg_d   = 1'b0;

            unique case (state_q)
                PHY_RST: begin
                    if (tmr_q == RST_LAST) begin
                        // Initial speed comes straight from the status; this
                        // is not a change, so no speed_change pulse.
                        state_d = POST_GAP;
                        sel_d   = code;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end

                RUN: begin
                    if (code == sel_q) begin
                        stab_d = '0;
                    end else if (code == cand_q) begin
                        if (stab_q == STAB_LAST) begin
                            // cand_q is only written in RUN, so it stays
                            // frozen through both gaps.
                            state_d = PRE_GAP;
                            stab_d  = '0;
                            tmr_d   = '0;
                        end else begin
                            stab_d = stab_inc;
                        end
                    end else begin
                        cand_d = code;
                        stab_d = SW'(1);
                    end
                end

                PRE_GAP: begin
                    if (tmr_q == GAP_LAST) begin
                        state_d = POST_GAP;
                        sel_d   = cand_q;
                        chg_d   = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end

                POST_GAP: begin
                    if (tmr_q == GAP_LAST) begin
                        state_d = RUN;
                        stab_d  = '0;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end

                default: state_d = PHY_RST;
            endcase

            // A PHY reset request overrides everything and restarts the hold
            // every cycle it is present; any pending switch is abandoned.
            if (bus.phy_rst_req[i]) begin
                state_d = PHY_RST;
                tmr_d   = '0;
                stab_d  = '0;
                chg_d   = 1'b0;
            end
        end

        assign phy_reset_n_w[i]        = (state_q != PHY_RST);
        assign tx_clk_en_w[i]          = (state_q == RUN);
        assign busy_w[i]               = (state_q != RUN);
        assign speed_change_w[i]       = chg_q;
        assign tx_clk_sel_w[2*i +: 2]  = sel_q;
    end

    assign bus.phy_reset_n  = phy_reset_n_w;
    assign bus.tx_clk_en    = tx_clk_en_w;
    assign bus.busy         = busy_w;
    assign bus.speed_change = speed_change_w;
    assign bus.tx_clk_sel   = tx_clk_sel_w;

endmodule

// File: doc/eth_speed_mgr.md
ETH_SPEED_MGR -- requirements
Module: eth_speed_mgr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of Ethernet ports managed (legal 1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, consecutive samples required to qualify a speed change (legal >=2).
REQ-003 SHALL have parameter GAP_CYCLES, default 64, clock-quiet cycles before and after a clock-select change (legal >=1).
REQ-004 SHALL have parameter PHY_RST_CYCLES, default 50000, PHY reset hold length in cycles (legal >=1).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port eth_mode  input  NUM_PORTS  per-port MAC status, 1 = GbE; asynchronous to clk.
REQ-008 SHALL have port ena_10  input  NUM_PORTS  per-port MAC status, 1 = 10 Mb; asynchronous to clk.
REQ-009 SHALL have port phy_rst_req  input  NUM_PORTS  per-port synchronous PHY reset request, level-sensitive.
REQ-010 SHALL have port phy_reset_n  output  NUM_PORTS  per-port active-low PHY reset.
REQ-011 SHALL have port tx_clk_sel  output  2*NUM_PORTS  per-port TX clock select, bits [2i+1:2i]: 00 = 25 MHz, 01 = 2.5 MHz, 10 = 125 MHz.
REQ-012 SHALL have port tx_clk_en  output  NUM_PORTS  per-port TX clock/gate enable.
REQ-013 SHALL have port speed_change  output  NUM_PORTS  per-port one-cycle pulse when tx_clk_sel updates.
REQ-014 SHALL have port busy  output  NUM_PORTS  per-port high whenever the port FSM is not in RUN.

Function
REQ-015 SHALL pass eth_mode and ena_10 of each port through a 2-flop synchroniser before use.
REQ-016 SHALL derive speed code from synchronised bits: eth_mode=1 -> 10 (ena_10 ignored); else ena_10=1 -> 01; else 00; code 11 never produced.
REQ-017 SHALL instantiate an independent FSM, stability counter and gap/reset counter per port; ports never interact.
REQ-018 SHALL use FSM states PHY_RST, RUN, PRE_GAP, POST_GAP.
REQ-019 PHY_RST: phy_reset_n=0, tx_clk_en=0; after PHY_RST_CYCLES cycles with phy_rst_req low, on the exit edge load tx_clk_sel with current code, set phy_reset_n=1, go to POST_GAP; no speed_change pulse.
REQ-020 RUN: tx_clk_en=1; stability counter increments each cycle the code differs from tx_clk_sel and equals the held candidate; a different differing code reloads candidate and sets counter to 1; code equal to tx_clk_sel clears counter.
REQ-021 RUN: on the edge registering the STABLE_CYCLES-th consecutive candidate sample, latch candidate, go to PRE_GAP, tx_clk_en=0.
REQ-022 PRE_GAP: hold GAP_CYCLES cycles; on exit edge tx_clk_sel<=latched candidate, speed_change=1 for exactly one cycle, go to POST_GAP.
REQ-023 POST_GAP: hold GAP_CYCLES cycles with tx_clk_en=0, then RUN with stability counter cleared.
REQ-024 Input changes during PRE_GAP/POST_GAP SHALL NOT alter the latched candidate; they are re-evaluated only in RUN.
REQ-025 phy_rst_req high in any state SHALL force PHY_RST on the next edge, reload the reset counter every cycle it stays high, and suppress any pending speed_change.
REQ-026 Counter widths SHALL be $clog2(max count+1); counters SHALL saturate, never wrap.
REQ-027 Latency: raw status change set up before edge 0 -> tx_clk_en low after edge STABLE_CYCLES+1.

Reset
REQ-028 While reset high, immediately and without clock: phy_reset_n=0, tx_clk_sel=00, tx_clk_en=0, speed_change=0, busy=1, synchronisers=0, counters=0, state PHY_RST.
REQ-029 On reset release each port SHALL execute the full PHY_RST sequence per REQ-019.

Verification (NUM_PORTS=2, STABLE_CYCLES=4, GAP_CYCLES=8, PHY_RST_CYCLES=16)
REQ-030 Reset release, port0 eth_mode=1 -> after edge 16 phy_reset_n[0]=1, tx_clk_sel[1:0]=10; tx_clk_en[0]=1 and busy[0]=0 8 edges later.
REQ-031 Port0 in RUN at 1G, eth_mode 1->0 before edge 0 -> tx_clk_en[0]=0 after edge 5; tx_clk_sel[1:0]=00 with one-cycle speed_change[0] after edge 13; tx_clk_en[0]=1 after edge 21.
REQ-032 Port0 in RUN, eth_mode dropped for 3 cycles then restored -> no state change, tx_clk_en[0] stays 1, no speed_change.
REQ-033 Both ports 100M->10M on same edge -> identical independent timing per REQ-031 on both, tx_clk_sel=01.
REQ-034 phy_rst_req[1] pulsed 1 cycle during PRE_GAP -> phy_reset_n[1]=0 next edge, held 16 cycles, no speed_change[1] pulse.
REQ-035 reset asserted mid-POST_GAP between edges -> all outputs at REQ-028 values before next edge.
